// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 types, round count and S-box table
package aes_pkg;
  localparam int AES_NR = 10;
  typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_state_e;
  typedef logic [0:127] aes_block_t;
  localparam logic [7:0] SBOX_TABLE [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[b];
  endfunction
endpackage

// File: rtl/aes_round_controller_if.sv
// aes_round_controller_if: plaintext/key/ciphertext handshake bundle
interface aes_round_controller_if #(parameter int KIDX_W = 4);
  import aes_pkg::*;
  logic in_valid, in_ready, out_valid, out_ready, busy;
  aes_block_t plaintext, round_key, ciphertext;
  logic [KIDX_W-1:0] rk_idx;
  modport slave(input in_valid, plaintext, round_key, out_ready, output in_ready, rk_idx, out_valid, ciphertext, busy);
  modport master(output in_valid, plaintext, round_key, out_ready, input in_ready, rk_idx, out_valid, ciphertext, busy);
endinterface

// File: rtl/aes_mix_columns.sv
// aes_mix_columns: AES MixColumns over all four columns
module aes_mix_columns import aes_pkg::*; (
  input  aes_block_t state_in,
  output aes_block_t state_out
);
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = state_in[32*c +: 8];
    assign a1 = state_in[32*c+8 +: 8];
    assign a2 = state_in[32*c+16 +: 8];
    assign a3 = state_in[32*c+24 +: 8];
    assign state_out[32*c +: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                    a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                    a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                    xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  end
endmodule

// File: rtl/aes_round.sv
// aes_round: combinational SubBytes, ShiftRows, optional MixColumns, AddRoundKey
module aes_round import aes_pkg::*; (
  input  aes_block_t state_in,
  input  aes_block_t round_key,
  input  logic       bypass_mix,
  output aes_block_t state_out
);
  aes_block_t shifted, mixed;
  // byte i sits at row i%4, column i/4; row r takes its byte from column c+r
  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign shifted[8*i +: 8] = sbox(state_in[32*(((i/4) + (i%4)) % 4) + 8*(i%4) +: 8]);
  end
  aes_mix_columns u_mix (.state_in(shifted), .state_out(mixed));
  assign state_out = (bypass_mix ? shifted : mixed) ^ round_key;
endmodule

// File: rtl/aes_round_controller.sv
// aes_round_controller: iterative AES-128 sequencer, one round per clock
module aes_round_controller import aes_pkg::*; #(
  parameter int NR     = AES_NR,
  parameter int KIDX_W = 4
) (
  input logic clk,
  input logic rst,
  aes_round_controller_if.slave bus
);
  aes_state_e state;
  logic [KIDX_W-1:0] roundCnt;
  aes_block_t stateReg, roundOut, ctReg;
  logic outValid, lastRound;
  assign lastRound = roundCnt == KIDX_W'(NR);
  aes_round u_round (.state_in(stateReg), .round_key(bus.round_key), .bypass_mix(lastRound), .state_out(roundOut));
  assign bus.in_ready   = state == IDLE && !rst;
  assign bus.busy       = state != IDLE;
  assign bus.rk_idx     = state == ROUND ? roundCnt : '0;
  assign bus.out_valid  = outValid;
  assign bus.ciphertext = ctReg;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      roundCnt <= '0;
      stateReg <= '0;
      ctReg    <= '0;
      outValid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          stateReg <= bus.plaintext ^ bus.round_key;
          roundCnt <= KIDX_W'(1);
          state    <= ROUND;
        end
        ROUND: begin
          stateReg <= roundOut;
          if (lastRound) begin
            ctReg    <= roundOut;
            outValid <= 1'b1;
            state    <= DONE;
          end else roundCnt <= roundCnt + 1'b1;
        end
        DONE: if (bus.out_ready) begin
          outValid <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
